// File: rtl/vgachargen_apb_bridge.sv
// APB slave bridging the CPU to the character-generator memories (ch_map, col_map, glyph RAM).
// Latency: map write 0 wait states, any read 1 wait state, glyph write (read-modify-write) 2 wait states.
// Backpressure: pready_o low during wait states; dropping psel_i mid-transfer aborts without writing.
//
// Ports:
//   clk_i, arstn_i                  clock, async active-low reset
//   psel_i/penable_i/pwrite_i/
//   paddr_i/pwdata_i                APB request
//   pready_o/prdata_o/pslverr_o     APB response
//   ch_map_*   : 8-bit character map port A (addr/data/wen out, rdata in, 1-cycle read latency)
//   col_map_*  : 8-bit colour map port (same shape as ch_map)
//   ch_t_rw_*  : 128-bit writable glyph table, written 32 bits at a time via read-modify-write
module vgachargen_apb_bridge #(
  parameter int CH_MAP_DEPTH = 2400,
  parameter int CH_T_DEPTH   = 128
) (
  input  logic         clk_i,
  input  logic         arstn_i,
  input  logic         psel_i,
  input  logic         penable_i,
  input  logic         pwrite_i,
  input  logic [31:0]  paddr_i,
  input  logic [31:0]  pwdata_i,
  output logic         pready_o,
  output logic [31:0]  prdata_o,
  output logic         pslverr_o,
  output logic [11:0]  ch_map_addr_o,
  output logic [7:0]   ch_map_data_o,
  output logic         ch_map_wen_o,
  input  logic [7:0]   ch_map_rdata_i,
  output logic [11:0]  col_map_addr_o,
  output logic [7:0]   col_map_data_o,
  output logic         col_map_wen_o,
  input  logic [7:0]   col_map_rdata_i,
  output logic [6:0]   ch_t_rw_addr_o,
  output logic [127:0] ch_t_rw_data_o,
  output logic         ch_t_rw_wen_o,
  input  logic [127:0] ch_t_rw_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR, S_RD1, S_RD2, S_RMW1, S_RMW2, S_RMW3, S_ERR
  } state_t;

  localparam logic [1:0] TGT_CH_MAP  = 2'd0;
  localparam logic [1:0] TGT_COL_MAP = 2'd1;
  localparam logic [1:0] TGT_CH_T    = 2'd2;

  state_t state_q, state_d;

  logic [1:0]   tgt_q;
  logic [1:0]   lane_q;
  logic [31:0]  wdata_q;
  logic [11:0]  ch_map_addr_q, col_map_addr_q;
  logic [7:0]   ch_map_data_q, col_map_data_q;
  logic [6:0]   ch_t_addr_q;
  logic [127:0] ch_t_data_q;

  // Address decode; only bits [15:2] are meaningful.
  logic [1:0]  region;
  logic [11:0] map_idx;
  logic [6:0]  glyph;
  logic        map_oob, glyph_oob, dec_err;
  logic        setup, access;
  logic        unused_paddr;

  assign unused_paddr = ^{paddr_i[31:16], paddr_i[1:0]};

  assign region    = paddr_i[15:14];
  assign map_idx   = paddr_i[13:2];
  assign glyph     = paddr_i[10:4];
  assign map_oob   = {20'd0, map_idx} >= 32'(CH_MAP_DEPTH);
  assign glyph_oob = {25'd0, glyph} >= 32'(CH_T_DEPTH);
  assign dec_err   = (region == 2'd3)
                   | ((region == TGT_CH_MAP || region == TGT_COL_MAP) && map_oob)
                   | ((region == TGT_CH_T) && ((paddr_i[13:11] != 3'd0) || glyph_oob));

  assign setup  = psel_i && !penable_i && (state_q == S_IDLE);
  assign access = psel_i && penable_i;

  // Glyph word with the addressed 32-bit lane replaced by the APB write data.
  logic [127:0] merged;
  always_comb begin
    merged = ch_t_rw_rdata_i;
    merged[{lane_q, 5'd0} +: 32] = wdata_q;
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q        <= S_IDLE;
      tgt_q          <= 2'd0;
      lane_q         <= 2'd0;
      wdata_q        <= 32'd0;
      ch_map_addr_q  <= 12'd0;
      ch_map_data_q  <= 8'd0;
      col_map_addr_q <= 12'd0;
      col_map_data_q <= 8'd0;
      ch_t_addr_q    <= 7'd0;
      ch_t_data_q    <= 128'd0;
    end else begin
      state_q <= state_d;
      if (setup && !dec_err) begin
        tgt_q   <= region;
        lane_q  <= paddr_i[3:2];
        wdata_q <= pwdata_i;
        case (region)
          TGT_CH_MAP: begin
            ch_map_addr_q <= map_idx;
            if (pwrite_i) ch_map_data_q <= pwdata_i[7:0];
          end
          TGT_COL_MAP: begin
            col_map_addr_q <= map_idx;
            if (pwrite_i) col_map_data_q <= pwdata_i[7:0];
          end
          default: ch_t_addr_q <= glyph;
        endcase
      end
      // Glyph RAM output is valid in RMW2 (address was presented since setup).
      if (state_q == S_RMW2 && psel_i) ch_t_data_q <= merged;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (setup) begin
          if (dec_err)                   state_d = S_ERR;
          else if (!pwrite_i)            state_d = S_RD1;
          else if (region == TGT_CH_T)   state_d = S_RMW1;
          else                           state_d = S_WR;
        end
      end
      S_RD1:   state_d = S_RD2;
      S_RMW1:  state_d = S_RMW2;
      S_RMW2:  state_d = S_RMW3;
      default: state_d = S_IDLE; // WR, RD2, RMW3, ERR complete in one cycle
    endcase
    // Master abandoned the transfer: return to IDLE without writing.
    if (state_q != S_IDLE && !psel_i) state_d = S_IDLE;
  end

  logic [31:0] rd_sel;
  always_comb begin
    rd_sel = 32'd0;
    case (tgt_q)
      TGT_CH_MAP:  rd_sel = {24'd0, ch_map_rdata_i};
      TGT_COL_MAP: rd_sel = {24'd0, col_map_rdata_i};
      default:     rd_sel = ch_t_rw_rdata_i[{lane_q, 5'd0} +: 32];
    endcase
  end

  assign pready_o  = (state_q == S_WR) || (state_q == S_RD2) ||
                     (state_q == S_RMW3) || (state_q == S_ERR);
  assign pslverr_o = (state_q == S_ERR);
  assign prdata_o  = (state_q == S_RD2) ? rd_sel : 32'd0;

  assign ch_map_wen_o  = (state_q == S_WR) && (tgt_q == TGT_CH_MAP) && access;
  assign col_map_wen_o = (state_q == S_WR) && (tgt_q == TGT_COL_MAP) && access;
  assign ch_t_rw_wen_o = (state_q == S_RMW3) && access;

  assign ch_map_addr_o  = ch_map_addr_q;
  assign ch_map_data_o  = ch_map_data_q;
  assign col_map_addr_o = col_map_addr_q;
  assign col_map_data_o = col_map_data_q;
  assign ch_t_rw_addr_o = ch_t_addr_q;
  assign ch_t_rw_data_o = ch_t_data_q;

endmodule

// File: tb/tb_vgachargen_apb_bridge.sv
module tb_vgachargen_apb_bridge;

  logic         clk_i = 1'b0;
  logic         arstn_i;
  logic         psel_i, penable_i, pwrite_i;
  logic [31:0]  paddr_i, pwdata_i;
  logic         pready_o, pslverr_o;
  logic [31:0]  prdata_o;
  logic [11:0]  ch_map_addr_o, col_map_addr_o;
  logic [7:0]   ch_map_data_o, col_map_data_o;
  logic         ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o;
  logic [7:0]   ch_map_rdata_i, col_map_rdata_i;
  logic [6:0]   ch_t_rw_addr_o;
  logic [127:0] ch_t_rw_data_o, ch_t_rw_rdata_i;

  vgachargen_apb_bridge dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .psel_i(psel_i), .penable_i(penable_i), .pwrite_i(pwrite_i),
    .paddr_i(paddr_i), .pwdata_i(pwdata_i),
    .pready_o(pready_o), .prdata_o(prdata_o), .pslverr_o(pslverr_o),
    .ch_map_addr_o(ch_map_addr_o), .ch_map_data_o(ch_map_data_o),
    .ch_map_wen_o(ch_map_wen_o), .ch_map_rdata_i(ch_map_rdata_i),
    .col_map_addr_o(col_map_addr_o), .col_map_data_o(col_map_data_o),
    .col_map_wen_o(col_map_wen_o), .col_map_rdata_i(col_map_rdata_i),
    .ch_t_rw_addr_o(ch_t_rw_addr_o), .ch_t_rw_data_o(ch_t_rw_data_o),
    .ch_t_rw_wen_o(ch_t_rw_wen_o), .ch_t_rw_rdata_i(ch_t_rw_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  waits;
    logic        chk_addr;
    logic [1:0]  tgt;
    logic [11:0] addr;
  } resp_t;

  typedef struct packed {
    logic [1:0]   tgt;
    logic [11:0]  addr;
    logic [127:0] data;
  } wr_t;

  resp_t rq[$];
  wr_t   wq[$];
  int    n_chk = 0;
  int    n_fail = 0;

  logic [7:0]   ch_mem  [4096];
  logic [7:0]   col_mem [4096];
  logic [127:0] gl_mem  [128];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Synchronous-read RAM models behind the bridge.
  task automatic bram();
    for (int i = 0; i < 4096; i++) begin ch_mem[i] = 8'h00; col_mem[i] = 8'h00; end
    for (int i = 0; i < 128; i++) gl_mem[i] = 128'd0;
    col_mem[2399] = 8'h5A;
    gl_mem[5] = {128{1'b1}};
    forever begin
      @(posedge clk_i);
      ch_map_rdata_i  <= ch_mem[ch_map_addr_o];
      col_map_rdata_i <= col_mem[col_map_addr_o];
      ch_t_rw_rdata_i <= gl_mem[ch_t_rw_addr_o];
      if (ch_map_wen_o)  ch_mem[ch_map_addr_o]  = ch_map_data_o;
      if (col_map_wen_o) col_mem[col_map_addr_o] = col_map_data_o;
      if (ch_t_rw_wen_o) gl_mem[ch_t_rw_addr_o] = ch_t_rw_data_o;
    end
  endtask

  // Scoreboard monitor: pops expected writes on any wen, expected responses on pready.
  task automatic monitor();
    int    acc = 0;
    resp_t r;
    wr_t   w;
    logic  have;
    logic [11:0] a;
    forever begin
      @(negedge clk_i);
      if (!arstn_i) begin
        acc = 0;
        if (ch_map_wen_o || col_map_wen_o || ch_t_rw_wen_o)
          chk("wen_in_reset", {ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}, 0);
        continue;
      end
      if (ch_map_wen_o || col_map_wen_o || ch_t_rw_wen_o) begin
        chk("wen_gated", psel_i && penable_i, 1);
        have = (wq.size() != 0);
        chk("wr_expected", have, 1);
        if (have) begin
          w = wq.pop_front();
          chk("wr_tgt", {ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o},
              (w.tgt == 2'd0) ? 3'b100 : (w.tgt == 2'd1) ? 3'b010 : 3'b001);
          case (w.tgt)
            2'd0: begin chk("wr_addr", ch_map_addr_o, w.addr);  chk("wr_data", ch_map_data_o, w.data); end
            2'd1: begin chk("wr_addr", col_map_addr_o, w.addr); chk("wr_data", col_map_data_o, w.data); end
            default: begin chk("wr_addr", ch_t_rw_addr_o, w.addr); chk("wr_data", ch_t_rw_data_o, w.data); end
          endcase
        end
      end
      if (psel_i && penable_i) begin
        acc++;
        if (pready_o) begin
          have = (rq.size() != 0);
          chk("resp_expected", have, 1);
          if (have) begin
            r = rq.pop_front();
            chk("prdata", prdata_o, r.rdata);
            chk("pslverr", pslverr_o, r.err);
            chk("wait_states", acc - 1, r.waits);
            if (r.chk_addr) begin
              a = (r.tgt == 2'd0) ? ch_map_addr_o :
                  (r.tgt == 2'd1) ? col_map_addr_o : {5'd0, ch_t_rw_addr_o};
              chk("mem_addr", a, r.addr);
            end
          end
          acc = 0;
        end
      end else begin
        acc = 0;
      end
    end
  endtask

  // One APB transfer; entered just after a rising edge, leaves just after the completing edge.
  task automatic apb(input logic wr, input logic [31:0] a, input logic [31:0] d);
    logic done = 1'b0;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr; paddr_i = a; pwdata_i = d;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      if (pready_o) begin done = 1'b1; break; end
    end
    chk("pready_seen", done, 1);
    @(posedge clk_i); #1;
    penable_i = 1'b0;
  endtask

  task automatic idle(input int n);
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic exp_resp(input logic [31:0] rd, input logic err, input logic [3:0] w,
                          input logic ca, input logic [1:0] t, input logic [11:0] ad);
    resp_t r;
    r.rdata = rd; r.err = err; r.waits = w; r.chk_addr = ca; r.tgt = t; r.addr = ad;
    rq.push_back(r);
  endtask

  task automatic exp_wr(input logic [1:0] t, input logic [11:0] ad, input logic [127:0] d);
    wr_t w;
    w.tgt = t; w.addr = ad; w.data = d;
    wq.push_back(w);
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk(nm, {pready_o, pslverr_o, prdata_o, ch_map_addr_o, ch_map_data_o, ch_map_wen_o,
             col_map_addr_o, col_map_data_o, col_map_wen_o, ch_t_rw_addr_o, ch_t_rw_wen_o}, 0);
    chk({nm, "_glyph_data"}, ch_t_rw_data_o, 0);
  endtask

  initial begin
    arstn_i = 1'b0; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
    paddr_i = 32'd0; pwdata_i = 32'd0;
    ch_map_rdata_i = 8'd0; col_map_rdata_i = 8'd0; ch_t_rw_rdata_i = 128'd0;
    fork
      bram();
      monitor();
    join_none
    repeat (2) @(posedge clk_i);
    #1;
    chk_outputs_zero("reset_state");
    arstn_i = 1'b1;
    idle(1);

    // ch_map write, zero wait states
    exp_wr(2'd0, 12'd4, 128'h41); exp_resp(0, 0, 0, 1, 2'd0, 12'd4);
    apb(1, 32'h0000_0010, 32'hABCD_0041);
    // col_map read of last cell, one wait state (back-to-back)
    exp_resp(32'h5A, 0, 1, 1, 2'd1, 12'd2399);
    apb(0, 32'h0000_657C, 32'h0);
    // glyph 5 lane 2 read-modify-write over all-ones
    exp_wr(2'd2, 12'd5, {32'hFFFF_FFFF, 32'hDEAD_BEEF, 64'hFFFF_FFFF_FFFF_FFFF});
    exp_resp(0, 0, 2, 1, 2'd2, 12'd5);
    apb(1, 32'h0000_8058, 32'hDEAD_BEEF);
    // decode errors: region 3, map index 2400, glyph bits [13:11] != 0
    exp_resp(0, 1, 0, 0, 2'd0, 12'd0); apb(1, 32'h0000_C000, 32'h1234_5678);
    exp_resp(0, 1, 0, 0, 2'd0, 12'd0); apb(0, 32'h0000_2580, 32'h0);
    exp_resp(0, 1, 0, 0, 2'd0, 12'd0); apb(1, 32'h0000_8800, 32'hFFFF_FFFF);
    // read-backs, upper address bits and byte offset ignored
    exp_resp(32'h41, 0, 1, 1, 2'd0, 12'd4); apb(0, 32'hFFFF_0013, 32'h0);
    exp_resp(32'hDEAD_BEEF, 0, 1, 1, 2'd2, 12'd5); apb(0, 32'h0000_8058, 32'h0);
    exp_resp(32'hFFFF_FFFF, 0, 1, 1, 2'd2, 12'd5); apb(0, 32'h0000_8050, 32'h0);
    idle(2);
    // col_map write + read
    exp_wr(2'd1, 12'd1, 128'h77); exp_resp(0, 0, 0, 1, 2'd1, 12'd1);
    apb(1, 32'h0000_4004, 32'h1234_5677);
    exp_resp(32'h77, 0, 1, 1, 2'd1, 12'd1); apb(0, 32'h0000_4004, 32'h0);
    // ch_map last valid index
    exp_wr(2'd0, 12'd2399, 128'hC3); exp_resp(0, 0, 0, 1, 2'd0, 12'd2399);
    apb(1, 32'h0000_257C, 32'h0000_00C3);
    exp_resp(32'hC3, 0, 1, 1, 2'd0, 12'd2399); apb(0, 32'h0000_257C, 32'h0);
    // last glyph, lane 3
    exp_wr(2'd2, 12'd127, {32'h1122_3344, 96'd0}); exp_resp(0, 0, 2, 1, 2'd2, 12'd127);
    apb(1, 32'h0000_87FC, 32'h1122_3344);
    exp_resp(32'h1122_3344, 0, 1, 1, 2'd2, 12'd127); apb(0, 32'h0000_87FC, 32'h0);

    // psel dropped after setup of a map write: no write may occur
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h30; pwdata_i = 32'h55;
    @(posedge clk_i); #1;
    idle(1);
    exp_resp(32'h0, 0, 1, 1, 2'd0, 12'd12); apb(0, 32'h0000_0030, 32'h0);

    // reset asserted during RMW2
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = 1'b1; paddr_i = 32'h8058; pwdata_i = 32'h0BAD_F00D;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    @(posedge clk_i); #1;
    arstn_i = 1'b0;
    #1;
    chk_outputs_zero("reset_mid_rmw");
    psel_i = 1'b0; penable_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    idle(1);
    exp_wr(2'd0, 12'd8, 128'h99); exp_resp(0, 0, 0, 1, 2'd0, 12'd8);
    apb(1, 32'h0000_0020, 32'h0000_0099);
    exp_resp(32'h99, 0, 1, 1, 2'd0, 12'd8); apb(0, 32'h0000_0020, 32'h0);
    exp_resp(32'hDEAD_BEEF, 0, 1, 1, 2'd2, 12'd5); apb(0, 32'h0000_8058, 32'h0);

    idle(3);
    chk("resp_queue_drained", rq.size(), 0);
    chk("wr_queue_drained", wq.size(), 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
